// File: rtl/audio_codec_serial.sv
// Master-mode, left-justified, 16-bit stereo serial port for a WM8731-class codec.
// Generates bclk/lrck, shifts playback data out on dacdat and capture data in from adcdat.
module audio_codec_serial #(
    parameter int BCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] audio_output,
    output logic [15:0] audio_input,
    output logic        sample_req,
    output logic        sample_end,
    output logic        lrck,
    output logic        bclk,
    output logic        dacdat,
    input  logic        adcdat
);

    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);
    localparam logic [3:0] SLOT_LAST = 4'd15;

    logic [7:0]  div_cnt;
    logic [3:0]  bit_cnt;
    logic [15:0] tx_shift;
    logic [14:0] rx_shift;
    logic        adc_meta;
    logic        adc_s;
    logic        tick;
    logic        rise_ev;
    logic        fall_ev;

    assign tick    = (div_cnt == DIV_LAST);
    assign rise_ev = tick & ~bclk;
    assign fall_ev = tick & bclk;

    // The MSB of the transmit shifter is the serial output, so dacdat changes
    // on the same clk edge that loads or shifts tx_shift.
    assign dacdat = tx_shift[15];

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            bclk        <= 1'b0;
            lrck        <= 1'b0;
            bit_cnt     <= SLOT_LAST;
            tx_shift    <= '0;
            rx_shift    <= '0;
            adc_meta    <= 1'b0;
            adc_s       <= 1'b0;
            audio_input <= '0;
            sample_req  <= 1'b0;
            sample_end  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // sees the pre-edge values of bclk, bit_cnt and the shifters.
            sample_req <= 1'b0;
            sample_end <= 1'b0;

            if (tick) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end

            adc_meta <= adcdat;
            adc_s    <= adc_meta;

            // The codec launches data on bclk falling edges; capture on rising.
            if (rise_ev) begin
                rx_shift <= {rx_shift[13:0], adc_s};
                if (bit_cnt == SLOT_LAST) begin
                    audio_input <= {rx_shift, adc_s};
                    sample_req  <= 1'b1;
                    sample_end  <= 1'b1;
                end
            end

            if (fall_ev) begin
                if (bit_cnt == SLOT_LAST) begin
                    bit_cnt  <= '0;
                    lrck     <= ~lrck;
                    tx_shift <= audio_output;
                end else begin
                    bit_cnt  <= bit_cnt + 4'd1;
                    tx_shift <= {tx_shift[14:0], 1'b0};
                end
            end
        end
    end

endmodule
